wb_write_queue: RTL and testbench

- Write-back end of the register file's single write port.
- Accepts completed results from the MEM/WB boundary through a valid/ready handshake and buffers them in a small in-order queue.
- Drains one entry per cycle onto the register file write port (we/wAddr/wData).
- Offers two bypass lookup ports so decode can read values that are queued but not yet written.

---
 rtl/wb_write_queue_pkg.sv | 25 ++
 rtl/wb_queue_entry_match.sv | 57 +++++
 rtl/wb_write_queue.sv | 149 ++++++++++++++
 tb/tb_wb_write_queue.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_write_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_queue_pkg
// Description : Shared widths and constants for the write-back queue. Widths
//               track the register-file bus (RegBus / RegAddrBus / RegNum).
//               No ports; imported by wb_write_queue and its bypass matcher.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_write_queue_pkg;

  localparam int REG_BUS_W  = 32;   // RegBus width
  localparam int REG_ADDR_W = 5;    // RegAddrBus width
  localparam int REG_NUM    = 32;   // number of GPRs

  // $0 is hard-wired; writes to it are dropped and lookups never hit.
  localparam logic [REG_ADDR_W-1:0] ZERO_REG_ADDR = '0;

  // Register-file port enable levels.
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;

endpackage : wb_write_queue_pkg
`default_nettype wire

// File: rtl/wb_queue_entry_match.sv
`default_nettype none
// ============================================================================
// Module      : wb_queue_entry_match
// Description : Bypass lookup for one decode port. Compares the lookup
//               address against every valid queue entry and returns the
//               youngest match (closest to the tail).
// Ports       : entry_valid/entry_addr/entry_data - queue storage snapshot
//               head_ptr    - index of the oldest entry
//               lookup_addr - register being read by decode
//               hit/data    - match flag and youngest matching value
// Revision    : 1.0 - initial release
// ============================================================================
module wb_queue_entry_match
  import wb_write_queue_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             entry_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] entry_data,
  input  logic [PTR_W-1:0]             head_ptr,
  input  logic [ADDR_W-1:0]            lookup_addr,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);

  logic [DEPTH-1:0] w_match;
  logic [PTR_W-1:0] w_idx;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
      assign w_match[i] = entry_valid[i] && (entry_addr[i] == lookup_addr);
    end
  endgenerate

  // Walk from head (oldest) toward tail; later matches overwrite earlier
  // ones so the youngest pending value is what decode sees.
  always_comb begin
    hit   = 1'b0;
    data  = '0;
    w_idx = '0;
    if (lookup_addr != ADDR_W'(ZERO_REG_ADDR)) begin
      for (int k = 0; k < DEPTH; k++) begin
        w_idx = head_ptr + PTR_W'(k);
        if (w_match[w_idx]) begin
          hit  = 1'b1;
          data = entry_data[w_idx];
        end
      end
    end
  end

endmodule : wb_queue_entry_match
`default_nettype wire

// File: rtl/wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_queue
// Description : Write-back queue in front of the register file's single
//               write port. Buffers MEM/WB results in order, drains one per
//               cycle, and exposes two bypass lookups for decode.
// Ports       : clk, rst (async active-low)
//               in_valid/in_ready/in_wreg/in_addr/in_data - result input
//               wr_hold  - register file port busy this cycle
//               we/wAddr/wData - register file write port
//               byp_addr*/byp_hit*/byp_data* - decode bypass lookups
//               pending  - number of queued entries
// Revision    : 1.0 - initial release
// ============================================================================
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wreg,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              wr_hold,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [DATA_W-1:0] wData,
  input  logic [ADDR_W-1:0] byp_addr1,
  output logic              byp_hit1,
  output logic [DATA_W-1:0] byp_data1,
  input  logic [ADDR_W-1:0] byp_addr2,
  output logic              byp_hit2,
  output logic [DATA_W-1:0] byp_data2,
  output logic [ADDR_W:0]   pending
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q,  addr_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q,  data_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q,  count_d;

  logic w_accept;
  logic w_push;
  logic w_pop;

  // Ready looks only at the registered count, so a full queue stays
  // not-ready even on the cycle it pops.
  assign in_ready = (count_q < C_DEPTH);
  assign w_accept = in_valid && in_ready;
  // Non-writing results and $0 targets consume the handshake but are dropped.
  assign w_push   = w_accept && in_wreg && (in_addr != ADDR_W'(ZERO_REG_ADDR));
  assign w_pop    = (count_q != '0) && !wr_hold;

  assign we      = w_pop ? WRITE_ENABLE : WRITE_DISABLE;
  assign wAddr   = w_pop ? addr_q[rd_ptr_q] : '0;
  assign wData   = w_pop ? data_q[rd_ptr_q] : '0;
  assign pending = (ADDR_W+1)'(count_q);

  always_comb begin
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // Pop first: a push can never target the head slot while it is valid
    // because pushes only happen when the queue is not full.
    if (w_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (w_push) begin
      valid_d[wr_ptr_q] = 1'b1;
      addr_d[wr_ptr_q]  = in_addr;
      data_d[wr_ptr_q]  = in_data;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The head entry keeps its valid bit during the cycle it is written, so
  // decode sees it here until the register file holds the value.
  wb_queue_entry_match #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_match1 (
    .entry_valid (valid_q),
    .entry_addr  (addr_q),
    .entry_data  (data_q),
    .head_ptr    (rd_ptr_q),
    .lookup_addr (byp_addr1),
    .hit         (byp_hit1),
    .data        (byp_data1)
  );

  wb_queue_entry_match #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_match2 (
    .entry_valid (valid_q),
    .entry_addr  (addr_q),
    .entry_data  (data_q),
    .head_ptr    (rd_ptr_q),
    .lookup_addr (byp_addr2),
    .hit         (byp_hit2),
    .data        (byp_data2)
  );

endmodule : wb_write_queue
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_write_queue
// Description : Self-checking bench for wb_write_queue: a cycle table of
//               inputs and expected outputs, a queue-based scoreboard checked
//               every cycle, plus streaming and async-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_write_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_wreg = 1'b0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              wr_hold = 1'b0;
  logic              we;
  logic [ADDR_W-1:0] wAddr;
  logic [DATA_W-1:0] wData;
  logic [ADDR_W-1:0] byp_addr1 = '0;
  logic              byp_hit1;
  logic [DATA_W-1:0] byp_data1;
  logic [ADDR_W-1:0] byp_addr2 = '0;
  logic              byp_hit2;
  logic [DATA_W-1:0] byp_data2;
  logic [ADDR_W:0]   pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_write_queue #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_wreg   (in_wreg),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .wr_hold   (wr_hold),
    .we        (we),
    .wAddr     (wAddr),
    .wData     (wData),
    .byp_addr1 (byp_addr1),
    .byp_hit1  (byp_hit1),
    .byp_data1 (byp_data1),
    .byp_addr2 (byp_addr2),
    .byp_hit2  (byp_hit2),
    .byp_data2 (byp_data2),
    .pending   (pending)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t exp_q[$];
  logic m_acc;
  logic m_pop;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      m_acc = in_valid && (exp_q.size() < DEPTH);
      m_pop = (exp_q.size() > 0) && !wr_hold;
      if (m_pop) void'(exp_q.pop_front());
      if (m_acc && in_wreg && (in_addr != 5'd0)) exp_q.push_back('{in_addr, in_data});
    end
  end

  function automatic logic [32:0] byp_lookup(input logic [ADDR_W-1:0] a);
    logic [32:0] r;
    r = '0;
    if (a != 5'd0)
      for (int i = 0; i < exp_q.size(); i++)
        if (exp_q[i].a == a) r = {1'b1, exp_q[i].d};
    return r;
  endfunction

  logic        e_we;
  logic [32:0] e_b1;
  logic [32:0] e_b2;

  always @(negedge clk) begin
    e_we = (exp_q.size() > 0) && !wr_hold;
    e_b1 = byp_lookup(byp_addr1);
    e_b2 = byp_lookup(byp_addr2);
    chk("sb_in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
    chk("sb_we", 32'(we), 32'(e_we));
    if (e_we) begin
      chk("sb_wAddr", 32'(wAddr), 32'(exp_q[0].a));
      chk("sb_wData", wData, exp_q[0].d);
    end else begin
      chk("sb_wAddr_idle", 32'(wAddr), 32'd0);
      chk("sb_wData_idle", wData, 32'd0);
    end
    chk("sb_pending", 32'(pending), 32'(exp_q.size()));
    chk("sb_hit1", 32'(byp_hit1), 32'(e_b1[32]));
    chk("sb_data1", byp_data1, e_b1[31:0]);
    chk("sb_hit2", 32'(byp_hit2), 32'(e_b2[32]));
    chk("sb_data2", byp_data2, e_b2[31:0]);
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic              v;
    logic              w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              h;
    logic [ADDR_W-1:0] b1;
    logic [ADDR_W-1:0] b2;
    logic              rdy;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              h1;
    logic [DATA_W-1:0] d1;
    logic              h2;
    logic [DATA_W-1:0] d2;
    logic [ADDR_W:0]   pend;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic v, input logic w, input logic [4:0] a, input logic [31:0] d,
    input logic h, input logic [4:0] b1, input logic [4:0] b2,
    input logic rdy, input logic e_we, input logic [4:0] wa, input logic [31:0] wd,
    input logic h1, input logic [31:0] d1, input logic h2, input logic [31:0] d2,
    input logic [5:0] pend);
    vec_t r;
    r.v = v; r.w = w; r.a = a; r.d = d; r.h = h; r.b1 = b1; r.b2 = b2;
    r.rdy = rdy; r.we = e_we; r.wa = wa; r.wd = wd;
    r.h1 = h1; r.d1 = d1; r.h2 = h2; r.d2 = d2; r.pend = pend;
    return r;
  endfunction

  initial begin
    //               v     w     addr   data          hold  b1     b2     rdy   we    wAddr  wData         h1    d1            h2    d2            pend
    // single write to r5
    vecs[0]  = mk(1'b1, 1'b1, 5'd5,  32'h12345678, 1'b0, 5'd5,  5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        6'd0);
    vecs[1]  = mk(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  5'd5,  1'b1, 1'b1, 5'd5,  32'h12345678, 1'b1, 32'h12345678, 1'b1, 32'h12345678, 6'd1);
    vecs[2]  = mk(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        6'd0);
    // $0 and non-writing results are dropped
    vecs[3]  = mk(1'b1, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  5'd7,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        6'd0);
    vecs[4]  = mk(1'b1, 1'b0, 5'd7,  32'h77,       1'b0, 5'd0,  5'd7,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        6'd0);
    vecs[5]  = mk(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        6'd0);
    // fill under hold, stalled third push, drain in order
    vecs[6]  = mk(1'b1, 1'b1, 5'd3,  32'hA,        1'b1, 5'd3,  5'd4,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        6'd0);
    vecs[7]  = mk(1'b1, 1'b1, 5'd4,  32'hB,        1'b1, 5'd3,  5'd4,  1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 32'hA,        1'b0, 32'h0,        6'd1);
    vecs[8]  = mk(1'b1, 1'b1, 5'd6,  32'hC,        1'b1, 5'd3,  5'd4,  1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 32'hA,        1'b1, 32'hB,        6'd2);
    vecs[9]  = mk(1'b1, 1'b1, 5'd6,  32'hC,        1'b0, 5'd3,  5'd4,  1'b0, 1'b1, 5'd3,  32'hA,        1'b1, 32'hA,        1'b1, 32'hB,        6'd2);
    vecs[10] = mk(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd3,  5'd4,  1'b1, 1'b1, 5'd4,  32'hB,        1'b0, 32'h0,        1'b1, 32'hB,        6'd1);
    vecs[11] = mk(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd3,  5'd4,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        6'd0);
    // youngest-wins bypass on r9
    vecs[12] = mk(1'b1, 1'b1, 5'd9,  32'h1,        1'b1, 5'd9,  5'd9,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        6'd0);
    vecs[13] = mk(1'b1, 1'b1, 5'd9,  32'h2,        1'b1, 5'd9,  5'd9,  1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 32'h1,        1'b1, 32'h1,        6'd1);
    vecs[14] = mk(1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 32'h2,        1'b1, 32'h2,        6'd2);
    vecs[15] = mk(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd9,  5'd9,  1'b0, 1'b1, 5'd9,  32'h1,        1'b1, 32'h2,        1'b1, 32'h2,        6'd2);
    vecs[16] = mk(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd9,  5'd9,  1'b1, 1'b1, 5'd9,  32'h2,        1'b1, 32'h2,        1'b1, 32'h2,        6'd1);
    vecs[17] = mk(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd9,  5'd9,  1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        6'd0);
    // push and pop on the same edge
    vecs[18] = mk(1'b1, 1'b1, 5'd10, 32'h55,       1'b0, 5'd10, 5'd11, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        6'd0);
    vecs[19] = mk(1'b1, 1'b1, 5'd11, 32'h66,       1'b0, 5'd10, 5'd11, 1'b1, 1'b1, 5'd10, 32'h55,       1'b1, 32'h55,       1'b0, 32'h0,        6'd1);
    vecs[20] = mk(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd10, 5'd11, 1'b1, 1'b1, 5'd11, 32'h66,       1'b0, 32'h0,        1'b1, 32'h66,       6'd1);
    vecs[21] = mk(1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd10, 5'd11, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        6'd0);

    // ---- reset state ----
    #1 rst = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_wAddr", 32'(wAddr), 32'd0);
    chk("rst_wData", wData, 32'd0);
    chk("rst_hit1", 32'(byp_hit1), 32'd0);
    chk("rst_hit2", 32'(byp_hit2), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // ---- table ----
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      #1;
      in_valid  = vecs[i].v;
      in_wreg   = vecs[i].w;
      in_addr   = vecs[i].a;
      in_data   = vecs[i].d;
      wr_hold   = vecs[i].h;
      byp_addr1 = vecs[i].b1;
      byp_addr2 = vecs[i].b2;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d_we", i), 32'(we), 32'(vecs[i].we));
      chk($sformatf("vec%0d_wAddr", i), 32'(wAddr), 32'(vecs[i].wa));
      chk($sformatf("vec%0d_wData", i), wData, vecs[i].wd);
      chk($sformatf("vec%0d_hit1", i), 32'(byp_hit1), 32'(vecs[i].h1));
      chk($sformatf("vec%0d_data1", i), byp_data1, vecs[i].d1);
      chk($sformatf("vec%0d_hit2", i), 32'(byp_hit2), 32'(vecs[i].h2));
      chk($sformatf("vec%0d_data2", i), byp_data2, vecs[i].d2);
      chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].pend));
    end

    // ---- streaming: one write per cycle, queue never backs up ----
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      in_wreg   = 1'b1;
      in_addr   = 5'(i + 1);
      in_data   = 32'(i);
      wr_hold   = 1'b0;
      byp_addr1 = 5'(i + 1);
      byp_addr2 = 5'(i);
      @(negedge clk);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      chk("stream_pending_le1", 32'(pending <= 6'd1), 32'd1);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);

    // ---- async reset with two entries queued ----
    #1;
    wr_hold = 1'b1; in_valid = 1'b1; in_wreg = 1'b1; in_addr = 5'd12; in_data = 32'hC0;
    @(posedge clk);
    #1 in_addr = 5'd13; in_data = 32'hD0;
    @(posedge clk);
    #1 in_valid = 1'b0; byp_addr1 = 5'd12; byp_addr2 = 5'd13;
    @(negedge clk);
    chk("pre_rst_pending", 32'(pending), 32'd2);
    chk("pre_rst_hit1", 32'(byp_hit1), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_we", 32'(we), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_hit1", 32'(byp_hit1), 32'd0);
    chk("mid_rst_hit2", 32'(byp_hit2), 32'd0);
    chk("mid_rst_pending", 32'(pending), 32'd0);
    wr_hold = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_write", 32'(we), 32'd0);
    end

    // ---- queue still works after reset ----
    @(posedge clk);
    #1 in_valid = 1'b1; in_wreg = 1'b1; in_addr = 5'd14; in_data = 32'hEE;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_we", 32'(we), 32'd1);
    chk("post_rst_wData", wData, 32'hEE);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_wb_write_queue
`default_nettype wire
